// File: rtl/flex_tx_pkg.sv
// Shared types and line levels for the framed parallel-to-serial transmitter.
package flex_tx_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/flex_pts_tx_if.sv
// Producer-facing handshake and serial line bundle of the transmitter.
interface flex_pts_tx_if #(
  parameter int unsigned NUM_BITS = 8
);

  logic [NUM_BITS-1:0] tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic                serial_out;
  logic                busy;
  logic                tx_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, serial_out, busy, tx_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, serial_out, busy, tx_done
  );

endinterface

// File: rtl/flex_pts_sr.sv
// Loadable shift register presenting one bit at a time; vacated bits fill with 1.
module flex_pts_sr #(
  parameter int unsigned NUM_BITS  = 8,
  parameter bit          SHIFT_MSB = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_enable,
  input  logic                shift_enable,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                serial_out
);

  logic [NUM_BITS-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '1;
    end else if (load_enable) begin
      sr_q <= parallel_in;
    end else if (shift_enable) begin
      if (SHIFT_MSB) begin
        sr_q <= {sr_q[NUM_BITS-2:0], 1'b1};
      end else begin
        sr_q <= {1'b1, sr_q[NUM_BITS-1:1]};
      end
    end
  end

  assign serial_out = SHIFT_MSB ? sr_q[NUM_BITS-1] : sr_q[0];

endmodule

// File: rtl/flex_pts_tx.sv
// Framed serial transmitter: start bit, NUM_BITS data bits, stop bit, each held
// CLKS_PER_BIT clocks; gapless back-to-back when a word arrives in the last stop cycle.
module flex_pts_tx
  import flex_tx_pkg::*;
#(
  parameter int unsigned NUM_BITS     = 8,
  parameter bit          SHIFT_MSB    = 1'b1,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  flex_pts_tx_if.slave  bus
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned BW = $clog2(NUM_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_PRE  = (CLKS_PER_BIT > 1) ? TW'(CLKS_PER_BIT - 2) : '0;
  localparam logic [BW-1:0] BIT_LAST  = BW'(NUM_BITS - 1);

  tx_state_t     state_q;
  logic [TW-1:0] tick_q;
  logic [BW-1:0] bit_q;
  logic          serial_out_q;
  logic          tx_ready_q;
  logic          busy_q;
  logic          tx_done_q;

  logic          accept_c;
  logic          last_tick_c;
  logic          last_bit_c;
  logic          shift_en_c;
  logic          sr_bit_c;

  always_comb begin
    accept_c    = bus.tx_valid && tx_ready_q;
    last_tick_c = (tick_q == TICK_LAST);
    last_bit_c  = (bit_q == BIT_LAST);
    // Shift as each data bit is copied to the line so the head is always the next bit.
    shift_en_c  = last_tick_c &&
                  ((state_q == TX_START) || ((state_q == TX_DATA) && !last_bit_c));
  end

  flex_pts_sr #(
    .NUM_BITS  (NUM_BITS),
    .SHIFT_MSB (SHIFT_MSB)
  ) u_sr (
    .clk          (clk),
    .rst          (rst),
    .load_enable  (accept_c),
    .shift_enable (shift_en_c),
    .parallel_in  (bus.tx_data),
    .serial_out   (sr_bit_c)
  );

  // Frame sequencer; every output flop is set up one cycle ahead of the cycle it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= TX_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      serial_out_q <= LINE_IDLE;
      tx_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      tx_done_q    <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        TX_IDLE: begin
          if (accept_c) begin
            state_q      <= TX_START;
            tick_q       <= '0;
            serial_out_q <= START_BIT;
            tx_ready_q   <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        TX_START: begin
          if (last_tick_c) begin
            state_q      <= TX_DATA;
            tick_q       <= '0;
            bit_q        <= '0;
            serial_out_q <= sr_bit_c;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        TX_DATA: begin
          if (last_tick_c) begin
            tick_q <= '0;
            if (last_bit_c) begin
              state_q      <= TX_STOP;
              serial_out_q <= STOP_BIT;
              if (CLKS_PER_BIT == 1) begin
                tx_done_q  <= 1'b1;
                tx_ready_q <= 1'b1;
              end
            end else begin
              bit_q        <= bit_q + BW'(1);
              serial_out_q <= sr_bit_c;
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        TX_STOP: begin
          if (last_tick_c) begin
            tick_q <= '0;
            if (accept_c) begin
              state_q      <= TX_START;
              serial_out_q <= START_BIT;
              tx_ready_q   <= 1'b0;
            end else begin
              state_q      <= TX_IDLE;
              serial_out_q <= LINE_IDLE;
              busy_q       <= 1'b0;
            end
          end else begin
            tick_q <= tick_q + TW'(1);
            if ((CLKS_PER_BIT > 1) && (tick_q == TICK_PRE)) begin
              tx_done_q  <= 1'b1;
              tx_ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q      <= TX_IDLE;
          serial_out_q <= LINE_IDLE;
          tx_ready_q   <= 1'b1;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.serial_out = serial_out_q;
  assign bus.tx_ready   = tx_ready_q;
  assign bus.busy       = busy_q;
  assign bus.tx_done    = tx_done_q;

endmodule

// File: tb/tb_flex_pts_tx.sv
// Directed bench for flex_pts_tx: one instance at 8/MSB/4 and one at 8/LSB/1.
module tb_flex_pts_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flex_pts_tx_if #(.NUM_BITS(8)) if0 ();
  flex_pts_tx_if #(.NUM_BITS(8)) if1 ();

  flex_pts_tx #(.NUM_BITS(8), .SHIFT_MSB(1'b1), .CLKS_PER_BIT(4)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  flex_pts_tx #(.NUM_BITS(8), .SHIFT_MSB(1'b0), .CLKS_PER_BIT(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  // Observation vector order: {serial_out, tx_done, tx_ready, busy}
  localparam logic [3:0] IDLE_OBS = 4'b1010;

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic [9:0] line;  // bit 9 goes on the line first
  } vec_t;

  vec_t vecs [6];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic int cpb_of(input int sel);
    return (sel == 0) ? 4 : 1;
  endfunction

  function automatic logic [3:0] obs(input int sel);
    if (sel == 0) return {if0.serial_out, if0.tx_done, if0.tx_ready, if0.busy};
    return {if1.serial_out, if1.tx_done, if1.tx_ready, if1.busy};
  endfunction

  function automatic logic [3:0] frame_exp(input logic [9:0] line, input int cpb, input int k);
    int   total;
    int   idx;
    logic last;
    total = 10 * cpb;
    idx   = 9 - ((k - 1) / cpb);
    last  = (k == total);
    return {line[idx], last, last, 1'b1};
  endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin
      if0.tx_valid = v;
      if0.tx_data  = d;
    end else begin
      if1.tx_valid = v;
      if1.tx_data  = d;
    end
  endtask

  task automatic check(input string name, input int cyc, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: {line,done,ready,busy} got %b expected %b", name, cyc, got, exp);
    end
  endtask

  // Entered at a negedge with the DUT idle; leaves at the negedge after the frame.
  task automatic run_frame(input string name, input int sel, input logic [7:0] d, input logic [9:0] line);
    int total;
    total = 10 * cpb_of(sel);
    drive(sel, 1'b1, d);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, ~d);
    for (int k = 1; k <= total; k++) begin
      check(name, k, obs(sel), frame_exp(line, cpb_of(sel), k));
      @(negedge clk);
    end
    check({name, "_idle"}, total + 1, obs(sel), IDLE_OBS);
  endtask

  // tx_valid held high; data advances only after the first word is taken.
  task automatic run_b2b(input string name, input int sel, input logic [7:0] d1, input logic [9:0] l1,
                         input logic [7:0] d2, input logic [9:0] l2);
    int total;
    total = 10 * cpb_of(sel);
    drive(sel, 1'b1, d1);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b1, d2);
    for (int k = 1; k <= 2 * total; k++) begin
      if (k <= total) check(name, k, obs(sel), frame_exp(l1, cpb_of(sel), k));
      else            check(name, k, obs(sel), frame_exp(l2, cpb_of(sel), k - total));
      if (k == total + 1) drive(sel, 1'b0, 8'h00);
      @(negedge clk);
    end
    check({name, "_idle"}, 2 * total + 1, obs(sel), IDLE_OBS);
  endtask

  initial begin
    vecs[0] = '{sel: 0, data: 8'hA5, line: 10'b0_10100101_1};
    vecs[1] = '{sel: 1, data: 8'hC1, line: 10'b0_10000011_1};
    vecs[2] = '{sel: 0, data: 8'h00, line: 10'b0_00000000_1};
    vecs[3] = '{sel: 0, data: 8'hFF, line: 10'b0_11111111_1};
    vecs[4] = '{sel: 1, data: 8'h35, line: 10'b0_10101100_1};
    vecs[5] = '{sel: 1, data: 8'h01, line: 10'b0_10000000_1};

    rst = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    check("reset_dut0", 0, obs(0), IDLE_OBS);
    check("reset_dut1", 0, obs(1), IDLE_OBS);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_dut0", 0, obs(0), IDLE_OBS);

    for (int i = 0; i < 6; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].sel, vecs[i].data, vecs[i].line);
      @(negedge clk);
    end

    run_b2b("b2b_0f_f0", 0, 8'h0F, 10'b0_00001111_1, 8'hF0, 10'b0_11110000_1);
    @(negedge clk);
    run_b2b("b2b_lsb_01_80", 1, 8'h01, 10'b0_10000000_1, 8'h80, 10'b0_00000001_1);
    @(negedge clk);

    // Word must be frozen at acceptance despite a new valid word during the frame.
    drive(0, 1'b1, 8'h3C);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b1, 8'hFF);
    for (int k = 1; k <= 40; k++) begin
      check("stable_3c", k, obs(0), frame_exp(10'b0_00111100_1, 4, k));
      if (k == 40) drive(0, 1'b0, 8'h00);
      @(negedge clk);
    end
    check("stable_3c_idle", 41, obs(0), IDLE_OBS);
    @(negedge clk);

    // Abort a frame with a two-cycle reset pulse launched in frame cycle 15.
    drive(0, 1'b1, 8'h5A);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    for (int k = 1; k <= 15; k++) begin
      check("pre_abort_5a", k, obs(0), frame_exp(10'b0_01011010_1, 4, k));
      if (k == 15) rst = 1'b1;
      @(negedge clk);
    end
    check("abort_c16", 16, obs(0), IDLE_OBS);
    check("abort_dut1", 16, obs(1), IDLE_OBS);
    @(negedge clk);
    check("abort_c17", 17, obs(0), IDLE_OBS);
    rst = 1'b0;
    for (int k = 18; k <= 22; k++) begin
      @(negedge clk);
      check("abort_quiet", k, obs(0), IDLE_OBS);
    end
    run_frame("after_abort_81", 0, 8'h81, 10'b0_10000001_1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
